// File: rtl/lsu_mem_port.sv
// Load/store initiator: decodes funct3 into a memory command, frames a one-cycle
// enable with stable address/data on both sides, and returns one extended response.
module lsu_mem_port #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_num,
    output logic [3:0]  mem_ctl,
    input  logic [31:0] mem_out
);

    localparam logic [2:0] LDB = 3'b001;
    localparam logic [2:0] LDH = 3'b010;
    localparam logic [2:0] LDW = 3'b011;
    localparam logic [2:0] STB = 3'b101;
    localparam logic [2:0] STH = 3'b110;
    localparam logic [2:0] STW = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_is_load;
    logic        r_err;
    logic [2:0]  r_f3;
    logic [2:0]  r_cmd;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_data;
    logic [31:0] r_rdata;

    logic        w_f3_ok;
    logic        w_misalign;
    logic        w_legal;
    logic [2:0]  w_cmd;
    logic [31:0] w_ext;

    always_comb begin
        w_cmd   = 3'b000;
        w_f3_ok = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000:  begin w_cmd = STB; w_f3_ok = 1'b1; end
                3'b001:  begin w_cmd = STH; w_f3_ok = 1'b1; end
                3'b010:  begin w_cmd = STW; w_f3_ok = 1'b1; end
                default: ;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b100: begin w_cmd = LDB; w_f3_ok = 1'b1; end
                3'b001, 3'b101: begin w_cmd = LDH; w_f3_ok = 1'b1; end
                3'b010:         begin w_cmd = LDW; w_f3_ok = 1'b1; end
                default: ;
            endcase
        end
        w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        w_legal    = w_f3_ok && !(ALIGN_CHECK && w_misalign);
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_ctl    = {1'b0, r_cmd};
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = w_legal ? S_SETUP : S_RESP;
            end
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: begin
                mem_ctl = {1'b1, r_cmd};
                w_next  = S_HOLD;
            end
            S_HOLD:   w_next = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // Memory returns zero-extended sub-words, so sign extension is applied here.
    always_comb begin
        w_ext = r_data;
        if (!r_is_load) begin
            w_ext = '0;
        end else begin
            case (r_f3)
                3'b000:  w_ext = {{24{r_data[7]}}, r_data[7:0]};
                3'b001:  w_ext = {{16{r_data[15]}}, r_data[15:0]};
                3'b100:  w_ext = {24'h000000, r_data[7:0]};
                3'b101:  w_ext = {16'h0000, r_data[15:0]};
                default: w_ext = r_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_is_load <= 1'b0;
            r_err     <= 1'b0;
            r_f3      <= '0;
            r_cmd     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_data    <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (w_legal) begin
                            r_addr    <= req_addr;
                            r_wdata   <= req_wdata;
                            r_cmd     <= w_cmd;
                            r_f3      <= req_funct3;
                            r_is_load <= !req_we;
                        end else begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end
                    end
                end
                S_ACCESS: r_data <= mem_out;
                S_HOLD: begin
                    r_rdata <= w_ext;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = r_addr;
    assign mem_num    = r_wdata;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: two instances (alignment checked / unchecked),
// each with its own byte memory, checked against a byte-array reference model.
module tb_lsu_mem_port;

    localparam logic [2:0] LDB = 3'b001;
    localparam logic [2:0] LDH = 3'b010;
    localparam logic [2:0] LDW = 3'b011;
    localparam logic [2:0] STB = 3'b101;
    localparam logic [2:0] STH = 3'b110;
    localparam logic [2:0] STW = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_init = 1'b1;
    int          sel = 0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b0;

    logic        obs_req_ready, obs_resp_valid, obs_resp_err;
    logic [31:0] obs_resp_rdata, obs_mem_addr, obs_mem_num;
    logic [3:0]  obs_mem_ctl;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] ref_mem [2][256];

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        return (i == 5) ? 8'h85 : 8'(i * 7 + 3);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic        rr, rv, re;
        logic [31:0] rd, ma, mn, mo;
        logic [3:0]  mc;
        logic [7:0]  mem [256];
        logic [7:0]  a;

        lsu_mem_port #(.ALIGN_CHECK(g == 0)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid && (sel == g)),
            .req_ready  (rr),
            .req_we     (req_we),
            .req_funct3 (req_funct3),
            .req_addr   (req_addr),
            .req_wdata  (req_wdata),
            .resp_valid (rv),
            .resp_ready (resp_ready),
            .resp_rdata (rd),
            .resp_err   (re),
            .mem_addr   (ma),
            .mem_num    (mn),
            .mem_ctl    (mc),
            .mem_out    (mo)
        );

        always_comb begin
            a = ma[7:0];
            case (mc[2:0])
                LDB:     mo = {24'h000000, mem[a]};
                LDH:     mo = {16'h0000, mem[a + 8'd1], mem[a]};
                default: mo = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
            endcase
        end

        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
            end else if (mc[3]) begin
                case (mc[2:0])
                    STB: mem[a] <= mn[7:0];
                    STH: begin
                        mem[a]        <= mn[7:0];
                        mem[a + 8'd1] <= mn[15:8];
                    end
                    STW: begin
                        mem[a]        <= mn[7:0];
                        mem[a + 8'd1] <= mn[15:8];
                        mem[a + 8'd2] <= mn[23:16];
                        mem[a + 8'd3] <= mn[31:24];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        if (sel == 0) begin
            obs_req_ready  = g_dut[0].rr;
            obs_resp_valid = g_dut[0].rv;
            obs_resp_err   = g_dut[0].re;
            obs_resp_rdata = g_dut[0].rd;
            obs_mem_addr   = g_dut[0].ma;
            obs_mem_num    = g_dut[0].mn;
            obs_mem_ctl    = g_dut[0].mc;
        end else begin
            obs_req_ready  = g_dut[1].rr;
            obs_resp_valid = g_dut[1].rv;
            obs_resp_err   = g_dut[1].re;
            obs_resp_rdata = g_dut[1].rd;
            obs_mem_addr   = g_dut[1].ma;
            obs_mem_num    = g_dut[1].mn;
            obs_mem_ctl    = g_dut[1].mc;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: what a request must return, given byte-addressed memory contents.
    function automatic void model(input int s, input logic we, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output bit legal, output logic [31:0] rd, output bit err);
        int  size;
        bit  ok, mis;
        logic [31:0] v;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        ok    = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis   = (size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00);
        legal = ok && !(s == 0 && mis);
        err   = !legal;
        rd    = '0;
        if (!legal) return;
        if (we) begin
            for (int k = 0; k < size; k++) ref_mem[s][(a + k) % 256] = 8'(wd >> (8 * k));
        end else begin
            v = '0;
            for (int k = 0; k < size; k++) v = v | (32'(ref_mem[s][(a + k) % 256]) << (8 * k));
            if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFFFF00;
            if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF0000;
            rd = v;
        end
    endfunction

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int bp, output logic [31:0] got);
        bit          legal, err;
        logic [31:0] rd;
        logic [2:0]  cmd;
        int          nc;
        model(sel, we, f3, a, wd, legal, rd, err);
        case (f3[1:0])
            2'd0:    cmd = we ? STB : LDB;
            2'd1:    cmd = we ? STH : LDH;
            default: cmd = we ? STW : LDW;
        endcase
        @(negedge clk);
        chk("idle_ready", 32'(obs_req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        nc = legal ? 4 : 1;
        for (int c = 1; c <= nc; c++) begin
            @(negedge clk);
            chk("busy_ready", 32'(obs_req_ready), 32'd0);
            chk("enable", 32'(obs_mem_ctl[3]), 32'(legal && c == 2));
            if (c < nc) chk("early_valid", 32'(obs_resp_valid), 32'd0);
            if (legal) begin
                chk("mem_addr", obs_mem_addr, a);
                chk("mem_num", obs_mem_num, wd);
                chk("mem_cmd", 32'(obs_mem_ctl[2:0]), 32'(cmd));
            end
        end
        chk("resp_valid", 32'(obs_resp_valid), 32'd1);
        chk("resp_rdata", obs_resp_rdata, rd);
        chk("resp_err", 32'(obs_resp_err), 32'(err));
        got = obs_resp_rdata;
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(obs_resp_valid), 32'd1);
            chk("bp_rdata", obs_resp_rdata, rd);
            chk("bp_err", 32'(obs_resp_err), 32'(err));
            chk("bp_ready", 32'(obs_req_ready), 32'd0);
            chk("bp_enable", 32'(obs_mem_ctl[3]), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("post_ready", 32'(obs_req_ready), 32'd1);
        chk("post_valid", 32'(obs_resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++) ref_mem[s][i] = init_byte(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(obs_req_ready), 32'd1);
        chk("rst_valid", 32'(obs_resp_valid), 32'd0);
        chk("rst_rdata", obs_resp_rdata, 32'd0);
        chk("rst_err", 32'(obs_resp_err), 32'd0);
        chk("rst_addr", obs_mem_addr, 32'd0);
        chk("rst_num", obs_mem_num, 32'd0);
        chk("rst_ctl", 32'(obs_mem_ctl), 32'd0);
        rst_n    = 1'b1;
        mem_init = 1'b0;

        run(1'b0, 3'd0, 32'h5, 32'h0, 0, got);          chk("lit_lb5", got, 32'hFFFFFF85);
        run(1'b0, 3'd4, 32'h5, 32'h0, 0, got);          chk("lit_lbu5", got, 32'h00000085);
        run(1'b1, 3'd2, 32'h40, 32'hDEAD8001, 0, got);  chk("lit_sw", got, 32'h0);
        run(1'b0, 3'd1, 32'h40, 32'h0, 0, got);         chk("lit_lh40", got, 32'hFFFF8001);
        run(1'b0, 3'd5, 32'h42, 32'h0, 0, got);         chk("lit_lhu42", got, 32'h0000DEAD);
        run(1'b0, 3'd2, 32'h41, 32'h0, 0, got);         chk("lit_mis_lw", got, 32'h0);
        run(1'b1, 3'd3, 32'h40, 32'h12345678, 0, got);
        run(1'b0, 3'd2, 32'h40, 32'h0, 0, got);         chk("lit_unchanged", got, 32'hDEAD8001);
        run(1'b0, 3'd2, 32'h40, 32'h0, 3, got);
        run(1'b1, 3'd0, 32'h10, 32'h11223388, 0, got);
        run(1'b1, 3'd1, 32'h20, 32'h5555BEEF, 1, got);
        run(1'b0, 3'd2, 32'h20, 32'h0, 0, got);         chk("lit_lw20", got, 32'hF8F1BEEF);
        run(1'b0, 3'd0, 32'h10, 32'h0, 0, got);         chk("lit_lb10", got, 32'hFFFFFF88);
        run(1'b0, 3'd1, 32'h21, 32'h0, 0, got);
        run(1'b0, 3'd4, 32'h21, 32'h0, 0, got);         chk("lit_lbu21", got, 32'h000000BE);
        run(1'b0, 3'd6, 32'h0, 32'h0, 0, got);
        run(1'b0, 3'd3, 32'h0, 32'h0, 0, got);
        run(1'b1, 3'd4, 32'h0, 32'hFFFFFFFF, 2, got);

        // Asynchronous reset in the middle of a load's enable cycle.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h40;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("acc_enable", 32'(obs_mem_ctl[3]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_ctl", 32'(obs_mem_ctl), 32'd0);
        chk("arst_valid", 32'(obs_resp_valid), 32'd0);
        chk("arst_ready", 32'(obs_req_ready), 32'd1);
        chk("arst_addr", obs_mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 3'd2, 32'h40, 32'h0, 0, got);         chk("lit_lw_after_rst", got, 32'hDEAD8001);

        sel = 1;
        run(1'b0, 3'd2, 32'h41, 32'h0, 0, got);         chk("lit_na_lw41", got, 32'hDFD8D1CA);
        run(1'b0, 3'd1, 32'h43, 32'h0, 0, got);         chk("lit_na_lh43", got, 32'hFFFFDFD8);
        run(1'b0, 3'd5, 32'h43, 32'h0, 0, got);         chk("lit_na_lhu43", got, 32'h0000DFD8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
